instr_fetch: RTL and testbench

//  Instruction fetch stage, directly upstream of the control unit: owns the PC, requests
//  32-bit instruction words from instruction memory over a req/ack handshake, and holds
//  the fetched word stable on instr (the control unit's instr input) until the core advances.

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/fetch_pc.sv | 50 +++++
 rtl/instr_fetch.sv | 102 ++++++++++
 tb/tb_instr_fetch.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
//   Shared types and constants for the CPU front end.
//   word_t        : 32-bit bus type used for addresses and instruction words
//   fetch_state_t : instruction-fetch FSM states
//   NOP_INSTR     : canonical no-op (addi x0, x0, 0) shown while nothing is fetched
//   word_align()  : clears the two low address bits
// -----------------------------------------------------------------------------
package cpu_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        ISSUED = 2'd2
    } fetch_state_t;

    localparam word_t NOP_INSTR = 32'h0000_0013;
    localparam word_t PC_STEP   = 32'd4;

    function automatic word_t word_align(input word_t addr);
        return addr & ~word_t'(3);
    endfunction

endpackage

// File: rtl/fetch_pc.sv
// -----------------------------------------------------------------------------
// fetch_pc
//   Program counter register and next-PC selection for the fetch stage.
//   Ports:
//     clk, rst  : clock, asynchronous active-high reset (loads RESET_PC)
//     advance   : retire the current instruction and move the PC this cycle
//     redirect  : when advancing, take target instead of pc + 4
//     target    : redirect address; low two bits are dropped
//     pc        : current PC
//     pc_plus4  : pc + 4, combinational (link value for jal/jalr)
// -----------------------------------------------------------------------------
module fetch_pc
    import cpu_pkg::*;
#(
    parameter word_t RESET_PC = 32'h0000_0000
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  advance,
    input  logic  redirect,
    input  word_t target,
    output word_t pc,
    output word_t pc_plus4
);

    word_t pc_q;
    word_t pc_d;

    always_comb begin
        // Modulo-2^32 add: 32'hFFFF_FFFC rolls over to 0 with no special case.
        pc_plus4 = pc_q + PC_STEP;
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        pc_d     = pc_q;
        if (advance) begin
            pc_d = redirect ? word_align(target) : pc_plus4;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   Instruction fetch stage: owns the PC, fetches 32-bit words over a req/ack
//   handshake and holds the fetched word on instr until the core advances.
//   Ports:
//     clk, rst                    : clock, asynchronous active-high reset
//     en                          : run enable; 0 parks the stage in IDLE between instructions
//     stall                       : downstream busy; holds the issued instruction
//     branch_taken, branch_target : redirect for the issued instruction (sampled in ISSUED)
//     imem_req, imem_addr         : memory request and address (= pc)
//     imem_ack, imem_rdata        : memory response (valid data while imem_ack=1)
//     instr, instr_valid          : fetched word and its issue strobe
//     pc, pc_plus4                : address of instr and its successor
// -----------------------------------------------------------------------------
module instr_fetch
    import cpu_pkg::*;
#(
    parameter word_t RESET_PC = 32'h0000_0000
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  en,
    input  logic  stall,
    input  logic  branch_taken,
    input  word_t branch_target,
    output logic  imem_req,
    output word_t imem_addr,
    input  logic  imem_ack,
    input  word_t imem_rdata,
    output word_t instr,
    output logic  instr_valid,
    output word_t pc,
    output word_t pc_plus4
);

    fetch_state_t state_q;
    fetch_state_t state_d;
    word_t        instr_q;
    word_t        instr_d;
    logic         advance;

    fetch_pc #(
        .RESET_PC (RESET_PC)
    ) u_fetch_pc (
        .clk      (clk),
        .rst      (rst),
        .advance  (advance),
        .redirect (branch_taken),
        .target   (branch_target),
        .pc       (pc),
        .pc_plus4 (pc_plus4)
    );

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        advance = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                // A fetch is never abandoned: en, stall and branch_taken are ignored here.
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = ISSUED;
                end
            end
            ISSUED: begin
                // Stall outranks a redirect; the execute path keeps branch_taken
                // asserted so it is taken on the cycle stall drops.
                if (!stall) begin
                    advance = 1'b1;
                    state_d = en ? FETCH : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            instr_q <= NOP_INSTR;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
        end
    end

    // Handshake and issue strobe are pure state decodes, so an asynchronous
    // reset drops imem_req in the same cycle it is applied.
    assign imem_req    = (state_q == FETCH);
    assign instr_valid = (state_q == ISSUED);
    assign imem_addr   = pc;
    assign instr       = instr_q;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;
    import cpu_pkg::*;

    // Main DUT (RESET_PC = 0)
    logic  clk = 1'b0;
    logic  rst;
    logic  en, stall, branch_taken;
    word_t branch_target;
    logic  imem_req, imem_ack, instr_valid;
    word_t imem_addr, imem_rdata, instr, pc, pc_plus4;

    // Second DUT for the address-wrap scenario
    logic  en_w, ack_w, req_w, valid_w;
    word_t rdata_w, addr_w, instr_w, pc_w, pc_plus4_w;

    int    n_checks = 0;
    int    n_pass   = 0;

    // Reference model state
    word_t model_pc;
    word_t exp_instr;

    // Memory responder controls
    int    ack_lat  = 1;
    int    wait_cnt = 0;
    bit    stray_en = 1'b0;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .en(en), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .instr_valid(instr_valid),
        .pc(pc), .pc_plus4(pc_plus4)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst), .en(en_w), .stall(1'b0),
        .branch_taken(1'b0), .branch_target(32'h0),
        .imem_req(req_w), .imem_addr(addr_w),
        .imem_ack(ack_w), .imem_rdata(rdata_w),
        .instr(instr_w), .instr_valid(valid_w),
        .pc(pc_w), .pc_plus4(pc_plus4_w)
    );

    // Instruction memory contents as a pure function of address.
    function automatic word_t mem_word(input word_t a);
        case (a)
            32'h0000_0000: return 32'h0010_0093;
            32'h0000_0004: return 32'h0020_0113;
            default:       return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
        endcase
    endfunction

    // Memory: acks after ack_lat request cycles (0 = same cycle); random
    // stray acks while no request is outstanding if stray_en is set.
    always begin
        @(posedge clk);
        #1;
        if (imem_req) begin
            if (wait_cnt >= ack_lat) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = $urandom;
                wait_cnt++;
            end
        end else begin
            wait_cnt   = 0;
            imem_ack   = stray_en ? 1'($urandom) : 1'b0;
            imem_rdata = $urandom;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One instruction: wait out the fetch, check the issue, stall, retire.
    task automatic run_instr(input string tag, input int stall_cycles, input bit do_branch,
                             input word_t target, input bit en_next, input bit noise,
                             input int next_lat);
        int  fetch_cycles = 0;
        int  lat = ack_lat;
        bit  done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            if (instr_valid) begin
                done = 1'b1;
            end else begin
                fetch_cycles++;
                n_checks++;
                if (imem_req !== 1'b1 || imem_addr !== model_pc)
                    $display("FAIL %s fetch req/addr: got req=%b addr=%h want req=1 addr=%h",
                             tag, imem_req, imem_addr, model_pc);
                else n_pass++;
                if (noise) begin
                    stall         = 1'($urandom);
                    branch_taken  = 1'($urandom);
                    branch_target = $urandom;
                    en            = 1'($urandom);
                end
                @(posedge clk);
                #1;
            end
        end
        if (!done) begin
            n_checks++;
            $display("FAIL %s fetch timeout: instr_valid=%b after 60 cycles, want 1", tag, instr_valid);
            return;
        end
        exp_instr = mem_word(model_pc);
        n_checks++;
        if (fetch_cycles !== lat + 1)
            $display("FAIL %s fetch length: got %0d cycles want %0d", tag, fetch_cycles, lat + 1);
        else n_pass++;
        n_checks++;
        if (instr !== exp_instr || pc !== model_pc || pc_plus4 !== model_pc + 32'd4 || imem_req !== 1'b0)
            $display("FAIL %s issue: got instr=%h pc=%h pc4=%h req=%b want instr=%h pc=%h pc4=%h req=0",
                     tag, instr, pc, pc_plus4, imem_req, exp_instr, model_pc, model_pc + 32'd4);
        else n_pass++;
        for (int s = 0; s < stall_cycles; s++) begin
            stall         = 1'b1;
            branch_taken  = noise ? 1'($urandom) : do_branch;
            branch_target = noise ? word_t'($urandom) : target;
            en            = noise ? 1'($urandom) : en_next;
            @(posedge clk);
            #1;
            n_checks++;
            if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== exp_instr || pc !== model_pc)
                $display("FAIL %s stall hold: got valid=%b req=%b instr=%h pc=%h want valid=1 req=0 instr=%h pc=%h",
                         tag, instr_valid, imem_req, instr, pc, exp_instr, model_pc);
            else n_pass++;
        end
        stall         = 1'b0;
        branch_taken  = do_branch;
        branch_target = target;
        en            = en_next;
        ack_lat       = next_lat;
        @(posedge clk);
        #1;
        branch_taken = 1'b0;
        model_pc     = do_branch ? (target & 32'hFFFF_FFFC) : model_pc + 32'd4;
        n_checks++;
        if (instr_valid !== 1'b0 || pc !== model_pc || pc_plus4 !== model_pc + 32'd4 ||
            imem_req !== en_next || imem_addr !== model_pc || instr !== exp_instr)
            $display("FAIL %s retire: got valid=%b pc=%h pc4=%h req=%b addr=%h instr=%h want valid=0 pc=%h pc4=%h req=%b addr=%h instr=%h",
                     tag, instr_valid, pc, pc_plus4, imem_req, imem_addr, instr,
                     model_pc, model_pc + 32'd4, en_next, model_pc, exp_instr);
        else n_pass++;
    endtask

    // Parked in IDLE with en=0 while memory throws stray acks.
    task automatic idle_cycles(input string tag, input int n);
        en       = 1'b0;
        stray_en = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== model_pc || instr !== exp_instr)
                $display("FAIL %s idle: got req=%b valid=%b pc=%h instr=%h want req=0 valid=0 pc=%h instr=%h",
                         tag, imem_req, instr_valid, pc, instr, model_pc, exp_instr);
            else n_pass++;
        end
        stray_en = 1'b0;
    endtask

    task automatic wake(input string tag);
        en = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== model_pc)
            $display("FAIL %s wake: got req=%b addr=%h want req=1 addr=%h", tag, imem_req, imem_addr, model_pc);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h0 || pc_plus4 !== 32'h4 || instr !== 32'h0000_0013)
            $display("FAIL reset values: got req=%b valid=%b pc=%h pc4=%h instr=%h want 0 0 00000000 00000004 00000013",
                     imem_req, instr_valid, pc, pc_plus4, instr);
        else n_pass++;
        #2 rst = 1'b0;
        model_pc  = 32'h0;
        exp_instr = 32'h0000_0013;
        idle_cycles("reset_idle", 3);
    endtask

    task automatic test_sequential();
        ack_lat = 1;
        wake("seq");
        run_instr("seq0", 0, 1'b0, 32'h0, 1'b1, 1'b0, 1);
        run_instr("seq1", 0, 1'b0, 32'h0, 1'b1, 1'b0, 0);
    endtask

    task automatic test_branch();
        n_checks++;
        if (imem_addr !== 32'h0000_0008)
            $display("FAIL branch setup addr: got %h want 00000008", imem_addr);
        else n_pass++;
        run_instr("branch", 0, 1'b1, 32'h0000_0043, 1'b1, 1'b0, 2);
        n_checks++;
        if (imem_addr !== 32'h0000_0040 || pc_plus4 !== 32'h0000_0044)
            $display("FAIL branch target: got addr=%h pc4=%h want 00000040 00000044", imem_addr, pc_plus4);
        else n_pass++;
    endtask

    task automatic test_stall();
        run_instr("stall", 5, 1'b1, 32'h0000_1236, 1'b1, 1'b0, 2);
    endtask

    task automatic test_slow_memory();
        run_instr("pre_slow", 0, 1'b0, 32'h0, 1'b1, 1'b0, 7);
        run_instr("slow", 0, 1'b0, 32'h0, 1'b0, 1'b0, 1);
        idle_cycles("slow_idle", 4);
    endtask

    task automatic test_reset_mid_fetch();
        ack_lat = 1;
        wake("mid_rst");
        @(posedge clk);
        #3;                      // responder has raised imem_ack; reset arrives mid-cycle
        rst = 1'b1;
        #1;
        n_checks++;
        if (imem_req !== 1'b0 || pc !== 32'h0 || instr !== 32'h0000_0013 || instr_valid !== 1'b0)
            $display("FAIL mid-fetch reset: got req=%b pc=%h instr=%h valid=%b want 0 00000000 00000013 0",
                     imem_req, pc, instr, instr_valid);
        else n_pass++;
        model_pc  = 32'h0;
        exp_instr = 32'h0000_0013;
        en        = 1'b0;
        stray_en  = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        idle_cycles("post_rst", 5);
    endtask

    task automatic test_random();
        int    stalls;
        bit    br, en_next;
        word_t tgt;
        ack_lat = 2;
        wake("rand");
        for (int k = 0; k < 40; k++) begin
            stalls  = $urandom_range(3, 0);
            br      = ($urandom_range(9, 0) < 3);
            tgt     = $urandom;
            en_next = (k != 39) && ($urandom_range(9, 0) < 8);
            run_instr($sformatf("rand%0d", k), stalls, br, tgt, en_next, 1'b1, $urandom_range(3, 0));
            if (!en_next) begin
                idle_cycles($sformatf("rand_idle%0d", k), $urandom_range(3, 1));
                if (k != 39) wake($sformatf("rand_wake%0d", k));
            end
        end
    endtask

    task automatic test_wrap();
        word_t w;
        w = $urandom;
        n_checks++;
        if (pc_w !== 32'hFFFF_FFFC || pc_plus4_w !== 32'h0 || req_w !== 1'b0)
            $display("FAIL wrap reset: got pc=%h pc4=%h req=%b want fffffffc 00000000 0", pc_w, pc_plus4_w, req_w);
        else n_pass++;
        en_w = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (req_w !== 1'b1 || addr_w !== 32'hFFFF_FFFC)
            $display("FAIL wrap fetch: got req=%b addr=%h want 1 fffffffc", req_w, addr_w);
        else n_pass++;
        ack_w   = 1'b1;
        rdata_w = w;
        @(posedge clk);
        #1;
        ack_w = 1'b0;
        en_w  = 1'b0;
        n_checks++;
        if (valid_w !== 1'b1 || instr_w !== w)
            $display("FAIL wrap issue: got valid=%b instr=%h want 1 %h", valid_w, instr_w, w);
        else n_pass++;
        @(posedge clk);
        #1;
        n_checks++;
        if (pc_w !== 32'h0 || valid_w !== 1'b0 || req_w !== 1'b0)
            $display("FAIL wrap advance: got pc=%h valid=%b req=%b want 00000000 0 0", pc_w, valid_w, req_w);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            ack_w   = 1'($urandom);
            rdata_w = $urandom;
            @(posedge clk);
            #1;
            n_checks++;
            if (req_w !== 1'b0 || valid_w !== 1'b0 || pc_w !== 32'h0 || instr_w !== w)
                $display("FAIL wrap park: got req=%b valid=%b pc=%h instr=%h want 0 0 00000000 %h",
                         req_w, valid_w, pc_w, instr_w, w);
            else n_pass++;
        end
        ack_w = 1'b0;
        en_w  = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (req_w !== 1'b1 || addr_w !== 32'h0)
            $display("FAIL wrap resume: got req=%b addr=%h want 1 00000000", req_w, addr_w);
        else n_pass++;
    endtask

    initial begin
        rst           = 1'b1;
        en            = 1'b0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        imem_ack      = 1'b0;
        imem_rdata    = 32'h0;
        en_w          = 1'b0;
        ack_w         = 1'b0;
        rdata_w       = 32'h0;
        test_reset();
        test_sequential();
        test_branch();
        test_stall();
        test_slow_memory();
        test_reset_mid_fetch();
        test_random();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
